// File: rtl/axi_rw_arbiter.sv
// ----------------------------------------------------------------------------
// axi_rw_arbiter
//
// Shares one AXI master port between the IFU (read-only) and the LSU
// (read and write). Only one transaction is in flight at a time. Its owner
// is fixed from the grant until that transaction's response handshake.
//
// Ports
//   clk_i, rst_i                 clock, asynchronous active-low reset
//   f_ar_* / f_r_*               IFU read address / read data channels
//   m_ar_* / m_r_*               LSU read address / read data channels
//   m_aw_* / m_w_* / m_b_*       LSU write address / data / response channels
//   mst_ar_* ... mst_b_*         shared master port toward the system bus
//
// Handshakes are forwarded combinationally from the registered state.
// Payload fields (addr, data, strb, resp) pass through without gating.
// Only valid and ready signals are qualified by the current owner.
// ----------------------------------------------------------------------------
module axi_rw_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,

    // IFU read channels
    input  logic                f_ar_valid_i,
    input  logic [ADDR_W-1:0]   f_ar_addr_i,
    output logic                f_ar_ready_o,
    output logic                f_r_valid_o,
    output logic [DATA_W-1:0]   f_r_data_o,
    output logic [1:0]          f_r_resp_o,
    input  logic                f_r_ready_i,

    // LSU read channels
    input  logic                m_ar_valid_i,
    input  logic [ADDR_W-1:0]   m_ar_addr_i,
    output logic                m_ar_ready_o,
    output logic                m_r_valid_o,
    output logic [DATA_W-1:0]   m_r_data_o,
    output logic [1:0]          m_r_resp_o,
    input  logic                m_r_ready_i,

    // LSU write channels
    input  logic                m_aw_valid_i,
    input  logic [ADDR_W-1:0]   m_aw_addr_i,
    output logic                m_aw_ready_o,
    input  logic                m_w_valid_i,
    input  logic [DATA_W-1:0]   m_w_data_i,
    input  logic [DATA_W/8-1:0] m_w_strb_i,
    output logic                m_w_ready_o,
    output logic                m_b_valid_o,
    output logic [1:0]          m_b_resp_o,
    input  logic                m_b_ready_i,

    // Shared master port
    output logic                mst_ar_valid_o,
    output logic [ADDR_W-1:0]   mst_ar_addr_o,
    input  logic                mst_ar_ready_i,
    input  logic                mst_r_valid_i,
    input  logic [DATA_W-1:0]   mst_r_data_i,
    input  logic [1:0]          mst_r_resp_i,
    output logic                mst_r_ready_o,
    output logic                mst_aw_valid_o,
    output logic [ADDR_W-1:0]   mst_aw_addr_o,
    input  logic                mst_aw_ready_i,
    output logic                mst_w_valid_o,
    output logic [DATA_W-1:0]   mst_w_data_o,
    output logic [DATA_W/8-1:0] mst_w_strb_o,
    input  logic                mst_w_ready_i,
    input  logic                mst_b_valid_i,
    input  logic [1:0]          mst_b_resp_i,
    output logic                mst_b_ready_o
);

    typedef enum logic [6:0] {
        IDLE = 7'b0000001,
        F_AR = 7'b0000010,
        F_R  = 7'b0000100,
        M_AR = 7'b0001000,
        M_R  = 7'b0010000,
        M_WR = 7'b0100000,
        M_B  = 7'b1000000
    } state_e;

    state_e state_q, state_d;
    logic   prior_q, prior_d;      // contention tie-break: 0 = IFU, 1 = LSU
    logic   aw_done_q, aw_done_d;
    logic   w_done_q, w_done_d;

    logic   f_req, m_req, grant_lsu;

    // Payload pass-through. Only the AR address needs a mux, because both
    // requesters can own the read-address channel.
    assign mst_ar_addr_o = (state_q == M_AR) ? m_ar_addr_i : f_ar_addr_i;
    assign mst_aw_addr_o = m_aw_addr_i;
    assign mst_w_data_o  = m_w_data_i;
    assign mst_w_strb_o  = m_w_strb_i;
    assign f_r_data_o    = mst_r_data_i;
    assign f_r_resp_o    = mst_r_resp_i;
    assign m_r_data_o    = mst_r_data_i;
    assign m_r_resp_o    = mst_r_resp_i;
    assign m_b_resp_o    = mst_b_resp_i;

    // Handshake routing. Each output is 0 unless the current state
    // makes its channel active for the owner.
    always_comb begin
        f_ar_ready_o   = 1'b0;
        f_r_valid_o    = 1'b0;
        m_ar_ready_o   = 1'b0;
        m_r_valid_o    = 1'b0;
        m_aw_ready_o   = 1'b0;
        m_w_ready_o    = 1'b0;
        m_b_valid_o    = 1'b0;
        mst_ar_valid_o = 1'b0;
        mst_r_ready_o  = 1'b0;
        mst_aw_valid_o = 1'b0;
        mst_w_valid_o  = 1'b0;
        mst_b_ready_o  = 1'b0;
        case (state_q)
            F_AR: begin
                mst_ar_valid_o = f_ar_valid_i;
                f_ar_ready_o   = mst_ar_ready_i;
            end
            F_R: begin
                f_r_valid_o    = mst_r_valid_i;
                mst_r_ready_o  = f_r_ready_i;
            end
            M_AR: begin
                mst_ar_valid_o = m_ar_valid_i;
                m_ar_ready_o   = mst_ar_ready_i;
            end
            M_R: begin
                m_r_valid_o    = mst_r_valid_i;
                mst_r_ready_o  = m_r_ready_i;
            end
            M_WR: begin
                // Once a channel has handshaken, hide it from both sides so
                // the beat cannot be issued twice.
                mst_aw_valid_o = m_aw_valid_i & ~aw_done_q;
                m_aw_ready_o   = mst_aw_ready_i & ~aw_done_q;
                mst_w_valid_o  = m_w_valid_i & ~w_done_q;
                m_w_ready_o    = mst_w_ready_i & ~w_done_q;
            end
            M_B: begin
                m_b_valid_o    = mst_b_valid_i;
                mst_b_ready_o  = m_b_ready_i;
            end
            default: ;
        endcase
    end

    // Next-state, arbitration and write-completion tracking
    always_comb begin
        state_d   = state_q;
        prior_d   = prior_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        f_req     = f_ar_valid_i;
        m_req     = m_aw_valid_i | m_ar_valid_i;
        grant_lsu = 1'b0;
        case (state_q)
            IDLE: begin
                if (f_req && m_req) begin
                    grant_lsu = prior_q;
                    prior_d   = ~prior_q;
                end else begin
                    grant_lsu = m_req;
                end
                if (f_req || m_req) begin
                    // A write takes precedence inside the LSU; its AR waits.
                    if (grant_lsu) begin
                        state_d = m_aw_valid_i ? M_WR : M_AR;
                    end else begin
                        state_d = F_AR;
                    end
                end
            end
            F_AR: if (mst_ar_valid_o && mst_ar_ready_i) state_d = F_R;
            F_R:  if (mst_r_valid_i && mst_r_ready_o)   state_d = IDLE;
            M_AR: if (mst_ar_valid_o && mst_ar_ready_i) state_d = M_R;
            M_R:  if (mst_r_valid_i && mst_r_ready_o)   state_d = IDLE;
            M_WR: begin
                aw_done_d = aw_done_q | (mst_aw_valid_o & mst_aw_ready_i);
                w_done_d  = w_done_q  | (mst_w_valid_o  & mst_w_ready_i);
                if (aw_done_d && w_done_d) begin
                    state_d   = M_B;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end
            M_B:  if (mst_b_valid_i && mst_b_ready_o)   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= IDLE;
            prior_q   <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            prior_q   <= prior_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

endmodule

// File: tb/tb_axi_rw_arbiter.sv
// ----------------------------------------------------------------------------
// tb_axi_rw_arbiter
//
// Directed cycle-by-cycle bench for axi_rw_arbiter. Inputs are driven 1 ns
// after each rising edge. Outputs are compared 2 ns after the edge, once the
// combinational routing has settled.
// ----------------------------------------------------------------------------
module tb_axi_rw_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic                clk_i = 1'b0;
    logic                rst_i;
    logic                f_ar_valid_i, f_ar_ready_o;
    logic [ADDR_W-1:0]   f_ar_addr_i;
    logic                f_r_valid_o, f_r_ready_i;
    logic [DATA_W-1:0]   f_r_data_o;
    logic [1:0]          f_r_resp_o;
    logic                m_ar_valid_i, m_ar_ready_o;
    logic [ADDR_W-1:0]   m_ar_addr_i;
    logic                m_r_valid_o, m_r_ready_i;
    logic [DATA_W-1:0]   m_r_data_o;
    logic [1:0]          m_r_resp_o;
    logic                m_aw_valid_i, m_aw_ready_o;
    logic [ADDR_W-1:0]   m_aw_addr_i;
    logic                m_w_valid_i, m_w_ready_o;
    logic [DATA_W-1:0]   m_w_data_i;
    logic [DATA_W/8-1:0] m_w_strb_i;
    logic                m_b_valid_o, m_b_ready_i;
    logic [1:0]          m_b_resp_o;
    logic                mst_ar_valid_o, mst_ar_ready_i;
    logic [ADDR_W-1:0]   mst_ar_addr_o;
    logic                mst_r_valid_i, mst_r_ready_o;
    logic [DATA_W-1:0]   mst_r_data_i;
    logic [1:0]          mst_r_resp_i;
    logic                mst_aw_valid_o, mst_aw_ready_i;
    logic [ADDR_W-1:0]   mst_aw_addr_o;
    logic                mst_w_valid_o, mst_w_ready_i;
    logic [DATA_W-1:0]   mst_w_data_o;
    logic [DATA_W/8-1:0] mst_w_strb_o;
    logic                mst_b_valid_i, mst_b_ready_o;
    logic [1:0]          mst_b_resp_i;

    int n_total = 0;
    int n_bad   = 0;

    // Every valid/ready output of the arbiter, for the "all quiet" checks
    logic [11:0] all_vr;
    assign all_vr = {f_ar_ready_o, f_r_valid_o, m_ar_ready_o, m_r_valid_o,
                     m_aw_ready_o, m_w_ready_o, m_b_valid_o, mst_ar_valid_o,
                     mst_r_ready_o, mst_aw_valid_o, mst_w_valid_o, mst_b_ready_o};

    always #5 clk_i = ~clk_i;

    axi_rw_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .f_ar_valid_i(f_ar_valid_i), .f_ar_addr_i(f_ar_addr_i), .f_ar_ready_o(f_ar_ready_o),
        .f_r_valid_o(f_r_valid_o), .f_r_data_o(f_r_data_o), .f_r_resp_o(f_r_resp_o),
        .f_r_ready_i(f_r_ready_i),
        .m_ar_valid_i(m_ar_valid_i), .m_ar_addr_i(m_ar_addr_i), .m_ar_ready_o(m_ar_ready_o),
        .m_r_valid_o(m_r_valid_o), .m_r_data_o(m_r_data_o), .m_r_resp_o(m_r_resp_o),
        .m_r_ready_i(m_r_ready_i),
        .m_aw_valid_i(m_aw_valid_i), .m_aw_addr_i(m_aw_addr_i), .m_aw_ready_o(m_aw_ready_o),
        .m_w_valid_i(m_w_valid_i), .m_w_data_i(m_w_data_i), .m_w_strb_i(m_w_strb_i),
        .m_w_ready_o(m_w_ready_o),
        .m_b_valid_o(m_b_valid_o), .m_b_resp_o(m_b_resp_o), .m_b_ready_i(m_b_ready_i),
        .mst_ar_valid_o(mst_ar_valid_o), .mst_ar_addr_o(mst_ar_addr_o),
        .mst_ar_ready_i(mst_ar_ready_i),
        .mst_r_valid_i(mst_r_valid_i), .mst_r_data_i(mst_r_data_i), .mst_r_resp_i(mst_r_resp_i),
        .mst_r_ready_o(mst_r_ready_o),
        .mst_aw_valid_o(mst_aw_valid_o), .mst_aw_addr_o(mst_aw_addr_o),
        .mst_aw_ready_i(mst_aw_ready_i),
        .mst_w_valid_o(mst_w_valid_o), .mst_w_data_o(mst_w_data_o), .mst_w_strb_o(mst_w_strb_o),
        .mst_w_ready_i(mst_w_ready_i),
        .mst_b_valid_i(mst_b_valid_i), .mst_b_resp_i(mst_b_resp_i), .mst_b_ready_o(mst_b_ready_o)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        // Reset held low while both requesters and the slave assert everything
        rst_i          = 1'b0;
        f_ar_valid_i   = 1'b1; f_ar_addr_i = 32'h0000_1000; f_r_ready_i = 1'b1;
        m_ar_valid_i   = 1'b1; m_ar_addr_i = 32'h0000_2000; m_r_ready_i = 1'b1;
        m_aw_valid_i   = 1'b0; m_aw_addr_i = '0;
        m_w_valid_i    = 1'b0; m_w_data_i  = '0; m_w_strb_i = '0;
        m_b_ready_i    = 1'b1;
        mst_ar_ready_i = 1'b1;
        mst_r_valid_i  = 1'b1; mst_r_data_i = 32'hCAFE_0001; mst_r_resp_i = 2'b00;
        mst_aw_ready_i = 1'b1; mst_w_ready_i = 1'b1;
        mst_b_valid_i  = 1'b1; mst_b_resp_i = 2'b00;
        cyc(); cyc(); #1;
        chk("rst_all_vr", all_vr, 0);

        // Release: IDLE cycle asserts nothing, then IFU wins (prior=0)
        cyc(); rst_i = 1'b1; mst_b_valid_i = 1'b0; #1;
        chk("idle0_all_vr", all_vr, 0);
        cyc(); #1;
        chk("g1_mst_arv",  mst_ar_valid_o, 1);
        chk("g1_ar_addr",  mst_ar_addr_o, 32'h0000_1000);
        chk("g1_f_ardy",   f_ar_ready_o, 1);
        chk("g1_m_ardy",   m_ar_ready_o, 0);
        cyc(); #1;
        chk("g1_f_rv",     f_r_valid_o, 1);
        chk("g1_m_rv",     m_r_valid_o, 0);
        chk("g1_f_rdata",  f_r_data_o, 32'hCAFE_0001);
        chk("g1_arv_off",  mst_ar_valid_o, 0);
        cyc(); #1;
        chk("idle1_all_vr", all_vr, 0);
        // Second contended grant goes to the LSU
        cyc(); #1;
        chk("g2_mst_arv",  mst_ar_valid_o, 1);
        chk("g2_ar_addr",  mst_ar_addr_o, 32'h0000_2000);
        chk("g2_m_ardy",   m_ar_ready_o, 1);
        chk("g2_f_ardy",   f_ar_ready_o, 0);
        cyc(); #1;
        chk("g2_m_rv",     m_r_valid_o, 1);
        chk("g2_f_rv",     f_r_valid_o, 0);
        cyc(); #1;
        chk("idle2_all_vr", all_vr, 0);
        // Third contended grant returns to the IFU
        cyc(); #1;
        chk("g3_ar_addr",  mst_ar_addr_o, 32'h0000_1000);
        chk("g3_m_ardy",   m_ar_ready_o, 0);
        cyc(); f_ar_valid_i = 1'b0; m_ar_valid_i = 1'b0; #1;
        chk("g3_f_rv",     f_r_valid_o, 1);
        cyc(); mst_r_valid_i = 1'b0; mst_aw_ready_i = 1'b0; mst_w_ready_i = 1'b0; #1;
        chk("idle3_all_vr", all_vr, 0);

        // A request withdrawn before the grant edge is not granted
        f_ar_valid_i = 1'b1; #2; f_ar_valid_i = 1'b0;
        cyc(); #1;
        chk("drop_all_vr", all_vr, 0);

        // LSU write: W ready three cycles before AW ready
        m_aw_valid_i = 1'b1; m_aw_addr_i = 32'h8000_0010;
        m_w_valid_i  = 1'b1; m_w_data_i  = 32'hDEAD_BEEF; m_w_strb_i = 4'hF;
        cyc(); mst_w_ready_i = 1'b1; #1;
        chk("wr_awv",      mst_aw_valid_o, 1);
        chk("wr_wv",       mst_w_valid_o, 1);
        chk("wr_aw_addr",  mst_aw_addr_o, 32'h8000_0010);
        chk("wr_w_data",   mst_w_data_o, 32'hDEAD_BEEF);
        chk("wr_w_strb",   mst_w_strb_o, 4'hF);
        chk("wr_m_wrdy",   m_w_ready_o, 1);
        chk("wr_m_awrdy",  m_aw_ready_o, 0);
        cyc(); #1;
        chk("wr1_wv_mask", mst_w_valid_o, 0);
        chk("wr1_wrdy",    m_w_ready_o, 0);
        chk("wr1_awv",     mst_aw_valid_o, 1);
        cyc(); #1;
        chk("wr2_awv",     mst_aw_valid_o, 1);
        cyc(); mst_aw_ready_i = 1'b1; #1;
        chk("wr3_m_awrdy", m_aw_ready_o, 1);
        cyc(); mst_aw_ready_i = 1'b0; m_aw_valid_i = 1'b0; m_w_valid_i = 1'b0; #1;
        chk("b0_awv",      mst_aw_valid_o, 0);
        chk("b0_m_bv",     m_b_valid_o, 0);
        chk("b0_bready",   mst_b_ready_o, 1);
        cyc(); mst_b_valid_i = 1'b1; mst_b_resp_i = 2'b00; #1;
        chk("b1_m_bv",     m_b_valid_o, 1);
        chk("b1_m_bresp",  m_b_resp_o, 2'b00);
        cyc(); #1;
        chk("wr_idle_all_vr", all_vr, 0);
        mst_b_valid_i = 1'b0;

        // LSU AR and AW together: write first, same-cycle AW/W completion
        m_aw_valid_i = 1'b1; m_w_valid_i = 1'b1;
        m_ar_valid_i = 1'b1; m_ar_addr_i = 32'h0000_3000;
        mst_aw_ready_i = 1'b1; mst_w_ready_i = 1'b1;
        cyc(); #1;
        chk("aa_awv",      mst_aw_valid_o, 1);
        chk("aa_arv",      mst_ar_valid_o, 0);
        chk("aa_m_ardy",   m_ar_ready_o, 0);
        cyc(); m_aw_valid_i = 1'b0; m_w_valid_i = 1'b0; mst_b_valid_i = 1'b1; #1;
        chk("aa_m_bv",     m_b_valid_o, 1);
        cyc(); mst_b_valid_i = 1'b0; #1;
        chk("aa_idle_arv", mst_ar_valid_o, 0);
        cyc(); #1;
        chk("aa_rd_arv",   mst_ar_valid_o, 1);
        chk("aa_rd_addr",  mst_ar_addr_o, 32'h0000_3000);
        chk("aa_rd_ardy",  m_ar_ready_o, 1);

        // Reset asserted in M_R with R valid from the slave
        cyc(); m_ar_valid_i = 1'b0; f_ar_valid_i = 1'b1;
        mst_r_valid_i = 1'b1; mst_r_data_i = 32'h1234_5678; #1;
        chk("mr_m_rv",     m_r_valid_o, 1);
        chk("mr_m_rdata",  m_r_data_o, 32'h1234_5678);
        rst_i = 1'b0; #1;
        chk("mr_rst_m_rv", m_r_valid_o, 0);
        chk("mr_rst_all",  all_vr, 0);
        cyc(); rst_i = 1'b1; #1;
        chk("post_idle_all", all_vr, 0);

        // Pending IFU read granted after release; slave answers SLVERR
        cyc(); mst_r_resp_i = 2'b10; #1;
        chk("se_arv",      mst_ar_valid_o, 1);
        chk("se_ar_addr",  mst_ar_addr_o, 32'h0000_1000);
        cyc(); f_ar_valid_i = 1'b0; #1;
        chk("se_f_rv",     f_r_valid_o, 1);
        chk("se_f_resp",   f_r_resp_o, 2'b10);
        chk("se_m_rv",     m_r_valid_o, 0);
        cyc(); mst_r_valid_i = 1'b0; #1;
        chk("se_idle_all", all_vr, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
